pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_ctrl_pkg.sv | 19 +
 rtl/sync_2ff.sv | 25 ++
 rtl/pll_reset_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and default timing for the PLL reset sequencer.
// Defaults assume a 12 MHz reference clock.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int CNT_W             = 16;
  localparam int DEF_RESET_CYCLES  = 12;
  localparam int DEF_LOCK_TIMEOUT  = 1200;
  localparam int DEF_STABLE_CYCLES = 120;
  localparam int DEF_MAX_RETRIES   = 3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals crossing into clk.
// Both stages clear on synchronous reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // first stage may go metastable, second stage settles it
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: resets the PLL, waits for a stable
// lock, then releases the system reset; retries and faults.
module pll_reset_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] RST_LD =
    CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LD =
    CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] STB_LD =
    CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           st;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;
  logic             lock;
  logic             reload;
  logic             retry_inc;
  logic             retry_clr;
  logic             loss_inc;
  logic             last_try;
  logic             resetb_d;
  logic             sys_rst_d;
  logic             ready_d;
  logic             fault_d;

  sync_2ff #(
    .WIDTH(1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (pll_locked),
    .q  (lock)
  );

  assign state    = st;
  assign last_try =
    (int'(retry_count) + 1) >= MAX_RETRIES;

  // state register and the shared phase timer
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= PLL_RESET;
      cnt <= RST_LD;
    end else begin
      st <= nxt;
      if (reload) begin
        cnt <= load_val;
      end else if (cnt != '0) begin
        cnt <= cnt - ONE;
      end
    end
  end

  // next state; restart outranks every other event
  always_comb begin
    nxt       = st;
    reload    = 1'b0;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    loss_inc  = 1'b0;
    if (restart) begin
      nxt       = PLL_RESET;
      reload    = 1'b1;
      retry_clr = 1'b1;
    end else begin
      unique case (st)
        PLL_RESET: begin
          if (cnt <= ONE) begin
            nxt    = WAIT_LOCK;
            reload = 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock) begin
            nxt    = STABLE;
            reload = 1'b1;
          end else if (cnt <= ONE) begin
            retry_inc = 1'b1;
            reload    = 1'b1;
            nxt = last_try ? FAULT : PLL_RESET;
          end
        end
        STABLE: begin
          if (!lock) begin
            nxt    = WAIT_LOCK;
            reload = 1'b1;
          end else if (cnt <= ONE) begin
            nxt       = RUN;
            reload    = 1'b1;
            retry_clr = 1'b1;
          end
        end
        RUN: begin
          if (!lock) begin
            nxt      = PLL_RESET;
            reload   = 1'b1;
            loss_inc = 1'b1;
          end
        end
        FAULT: begin
          nxt = FAULT;
        end
        default: begin
          nxt    = PLL_RESET;
          reload = 1'b1;
        end
      endcase
    end
  end

  // outputs and timer load follow the state being entered
  always_comb begin
    resetb_d  = 1'b1;
    sys_rst_d = 1'b1;
    ready_d   = 1'b0;
    fault_d   = 1'b0;
    load_val  = '0;
    unique case (nxt)
      PLL_RESET: begin
        resetb_d = 1'b0;
        load_val = RST_LD;
      end
      WAIT_LOCK: load_val = TMO_LD;
      STABLE:    load_val = STB_LD;
      RUN: begin
        sys_rst_d = 1'b0;
        ready_d   = 1'b1;
      end
      FAULT: begin
        resetb_d = 1'b0;
        fault_d  = 1'b1;
      end
      default: begin
        resetb_d = 1'b0;
        load_val = RST_LD;
      end
    endcase
  end

  // registered pin and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pll_resetb <= 1'b0;
      sys_rst    <= 1'b1;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      pll_resetb <= resetb_d;
      sys_rst    <= sys_rst_d;
      ready      <= ready_d;
      fault      <= fault_d;
    end
  end

  // failed-attempt counter, cleared on restart or lock
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_count <= '0;
    end else if (retry_clr) begin
      retry_count <= '0;
    end else if (retry_inc) begin
      retry_count <= retry_count + 2'd1;
    end
  end

  // lock losses seen in RUN, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_loss_count <= '0;
    end else if (loss_inc &&
                 lock_loss_count != 8'hFF) begin
      lock_loss_count <= lock_loss_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed table, corner
// sequences and random traffic against a phase model.
module tb_pll_reset_sequencer;

  localparam int RC = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int MR = 3;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_RUN  = 3;
  localparam int P_FLT  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_resetb;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  bit model_on = 0;

  int m_phase = P_RST;
  int m_el = 0;
  int m_retries = 0;
  int m_losses = 0;
  bit pin_q[$];

  pll_reset_sequencer #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .restart        (restart),
    .pll_resetb     (pll_resetb),
    .sys_rst        (sys_rst),
    .ready          (ready),
    .fault          (fault),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count),
    .state          (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r;
    bit rs;
    bit pin;
    int cyc;
    int st;
    bit rb;
    bit sr;
    bit rdy;
    bit flt;
    int rty;
    int llc;
  } vec_t;

  // one clock edge of the reference behaviour
  task automatic model_step();
    bit lk;
    lk = pin_q[0];
    pin_q.pop_front();
    pin_q.push_back(pll_locked);
    if (rst) begin
      m_phase = P_RST;
      m_el = 0;
      m_retries = 0;
      m_losses = 0;
      pin_q = '{1'b0, 1'b0};
    end else if (restart) begin
      m_phase = P_RST;
      m_el = 0;
      m_retries = 0;
    end else begin
      case (m_phase)
        P_RST: begin
          m_el++;
          if (m_el >= RC) begin
            m_phase = P_WAIT;
            m_el = 0;
          end
        end
        P_WAIT: begin
          if (lk) begin
            m_phase = P_STAB;
            m_el = 0;
          end else begin
            m_el++;
            if (m_el >= LT) begin
              m_retries++;
              m_el = 0;
              m_phase = (m_retries == MR) ? P_FLT : P_RST;
            end
          end
        end
        P_STAB: begin
          if (!lk) begin
            m_phase = P_WAIT;
            m_el = 0;
          end else begin
            m_el++;
            if (m_el >= SC) begin
              m_phase = P_RUN;
              m_retries = 0;
            end
          end
        end
        P_RUN: begin
          if (!lk) begin
            m_phase = P_RST;
            m_el = 0;
            if (m_losses < 255) m_losses++;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic model_cmp();
    logic [16:0] exp_v;
    logic [16:0] act_v;
    exp_v = {3'(m_phase),
             1'(m_phase != P_RST && m_phase != P_FLT),
             1'(m_phase != P_RUN),
             1'(m_phase == P_RUN),
             1'(m_phase == P_FLT),
             2'(m_retries), 8'(m_losses)};
    act_v = {state, pll_resetb, sys_rst, ready, fault,
             retry_count, lock_loss_count};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model t=%0t got %h want %h",
               $time, act_v, exp_v);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      if (model_on) model_cmp();
    end
  endtask

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    restart = 1'b0;
    step(1);
    model_on = 1;
    rst = 1'b0;
  endtask

  task automatic wait_phase(input int target, input int bound,
                            input string name);
    int n;
    n = 0;
    while (m_phase != target && n < bound) begin
      step(1);
      n++;
    end
    checks++;
    if (m_phase != target) begin
      errors++;
      $display("FAIL %s phase %0d want %0d after %0d cycles",
               name, m_phase, target, n);
    end
  endtask

  vec_t tbl[$];
  int   prob;

  initial begin
    pin_q = '{1'b0, 1'b0};

    tbl.push_back('{1,0,0, 1, 0,0,1,0,0, 0,0});
    tbl.push_back('{0,0,0, 3, 0,0,1,0,0, 0,0});
    tbl.push_back('{0,0,0, 1, 1,1,1,0,0, 0,0});
    tbl.push_back('{0,0,0, 6, 1,1,1,0,0, 0,0});
    tbl.push_back('{0,0,1, 2, 1,1,1,0,0, 0,0});
    tbl.push_back('{0,0,1, 1, 2,1,1,0,0, 0,0});
    tbl.push_back('{0,0,1, 7, 2,1,1,0,0, 0,0});
    tbl.push_back('{0,0,1, 1, 3,1,0,1,0, 0,0});
    tbl.push_back('{0,0,0, 2, 3,1,0,1,0, 0,0});
    tbl.push_back('{0,0,0, 1, 0,0,1,0,0, 0,1});
    tbl.push_back('{0,0,0, 4, 1,1,1,0,0, 0,1});
    tbl.push_back('{0,0,0,20, 0,0,1,0,0, 1,1});
    tbl.push_back('{0,0,0,24, 0,0,1,0,0, 2,1});
    tbl.push_back('{0,0,0,24, 4,0,1,0,1, 3,1});
    tbl.push_back('{0,0,0, 5, 4,0,1,0,1, 3,1});
    tbl.push_back('{0,1,0, 1, 0,0,1,0,0, 0,1});
    tbl.push_back('{0,0,0, 1, 0,0,1,0,0, 0,1});

    foreach (tbl[i]) begin
      rst = tbl[i].r;
      restart = tbl[i].rs;
      pll_locked = tbl[i].pin;
      step(tbl[i].cyc);
      if (tbl[i].r) model_on = 1;
      chk($sformatf("vec%0d.state", i),
          int'(state), tbl[i].st);
      chk($sformatf("vec%0d.pll_resetb", i),
          int'(pll_resetb), int'(tbl[i].rb));
      chk($sformatf("vec%0d.sys_rst", i),
          int'(sys_rst), int'(tbl[i].sr));
      chk($sformatf("vec%0d.ready", i),
          int'(ready), int'(tbl[i].rdy));
      chk($sformatf("vec%0d.fault", i),
          int'(fault), int'(tbl[i].flt));
      chk($sformatf("vec%0d.retry", i),
          int'(retry_count), tbl[i].rty);
      chk($sformatf("vec%0d.llc", i),
          int'(lock_loss_count), tbl[i].llc);
    end
    rst = 1'b0;
    restart = 1'b0;

    // one-cycle glitch while counting stable lock
    pll_locked = 1'b1;
    do_reset();
    step(7);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(1);
    chk("glitch.still_stable", int'(state), 2);
    step(1);
    chk("glitch.back_wait", int'(state), 1);
    step(1);
    chk("glitch.restable", int'(state), 2);
    step(7);
    chk("glitch.not_yet", int'(ready), 0);
    step(1);
    chk("glitch.ready", int'(ready), 1);
    chk("glitch.retry", int'(retry_count), 0);

    // restart on the cycle stable would complete
    do_reset();
    step(12);
    chk("simul.pre_state", int'(state), 2);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("simul.state", int'(state), 0);
    chk("simul.ready", int'(ready), 0);

    // repeated lock loss saturates the counter
    wait_phase(P_RUN, 40, "sat.first_run");
    for (int i = 0; i < 256; i++) begin
      pll_locked = 1'b0;
      wait_phase(P_RST, 10, "sat.loss");
      if (i == 0)
        chk("sat.first_loss", int'(lock_loss_count), 1);
      pll_locked = 1'b1;
      wait_phase(P_RUN, 60, "sat.relock");
    end
    chk("sat.llc", int'(lock_loss_count), 255);

    // restart in RUN keeps the loss count
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("rs_run.state", int'(state), 0);
    chk("rs_run.llc", int'(lock_loss_count), 255);

    // rst in RUN returns everything to reset values
    wait_phase(P_RUN, 40, "rst_run.run");
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_run.state", int'(state), 0);
    chk("rst_run.resetb", int'(pll_resetb), 0);
    chk("rst_run.sys_rst", int'(sys_rst), 1);
    chk("rst_run.ready", int'(ready), 0);
    chk("rst_run.fault", int'(fault), 0);
    chk("rst_run.retry", int'(retry_count), 0);
    chk("rst_run.llc", int'(lock_loss_count), 0);

    // random traffic against the model
    prob = 30;
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) begin
        case ($urandom_range(0, 2))
          0: prob = 4;
          1: prob = 40;
          default: prob = 400;
        endcase
      end
      if ($urandom_range(0, prob - 1) == 0)
        pll_locked = ~pll_locked;
      rst = ($urandom_range(0, 799) == 0);
      restart = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0;
    restart = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
